apb_accel_reg_slave: RTL and testbench
======================================

Name: apb_accel_reg_slave

Overview:
- APB3/APB4 completer (responder) for the accelerator subsystem. It holds the register map driven by the APB initiator: image words, the command register, the result register and the model-parameter register.
- It presents the 1024-bit image and the model parameters to the image glue/classifier path and issues a one-cycle start pulse.
- It tracks busy/done state and captures the classification result.
- It inserts programmable wait states and flags protocol/access errors on PSLVERR.

Parameters:
- WAIT_STATES, 1, extra PREADY-low cycles in access phase (0..15)
- ID_VALUE, 32'hACC0_0001, read-only ID word at index 0

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_PSEL  in  1  APB select
- i_PENABLE  in  1  APB enable
- i_PWRITE  in  1  1=write
- i_PADDR  in  10  word index [11:2]
- i_PWDATA  in  32  write data
- i_PSTRB  in  4  byte strobes
- o_PRDATA  out  32  read data
- o_PREADY  out  1  transfer complete
- o_PSLVERR  out  1  transfer error
- i_result_valid  in  1  one-cycle pulse, classifier finished
- i_result_class  in  4  class index, valid with i_result_valid
- o_img_data  out  1024  word k at bits [32k+31:32k], k=0..31
- o_model_params  out  19  {classes[18:15], clauses[14:6], stride[5:3], patch[2:0]}
- o_start  out  1  one-cycle inference start pulse

Behaviour:
- Reset (synchronous, all outputs):
  - o_PREADY=0, o_PSLVERR=0, o_PRDATA=0, o_start=0.
  - All image words=0, o_model_params=0, busy=0, done=0, result=0.
  - Reset mid-transfer aborts it with no commit.
- Register map (word index):
  - 0 ID (RO).
  - 1 STATUS: bit0 busy (RO), bit1 done (W1C).
  - 10..41 IMG word 0..31 (RW, PSTRB honoured).
  - 42 CMD: bit0=1 starts inference; reads 0.
  - 43 RESULT (RO): {23'b0, valid[8], 4'b0, class[3:0]}; valid mirrors done.
  - 44 MODEL_PARAMS (RW, bits[18:0], PSTRB honoured; upper bits read 0).
  - Any other index is unmapped.
- FSM states and transitions:
  - IDLE: on PSEL&PENABLE, load cnt=WAIT_STATES. Go to WAIT if cnt>0, else RESP.
  - WAIT: decrement cnt; at 0 go to RESP.
  - RESP: o_PREADY=1, o_PRDATA/o_PSLVERR valid. Return to IDLE next cycle.
  - Access phase therefore lasts WAIT_STATES+2 cycles.
  - PSEL or PENABLE dropping in WAIT or RESP: return to IDLE, no commit, o_PREADY=0.
- o_PRDATA is 0 outside RESP and on writes.
- Writes commit at the clock edge ending RESP, only when no error.
- PSLVERR=1 when any of these holds; the write is discarded and state is unchanged:
  - unmapped index (read or write);
  - write to index 0, 43 or 1 bit0;
  - write to IMG, CMD or MODEL_PARAMS while busy.
- Reads are never blocked by busy.
- Start:
  - A CMD write with bit0=1, busy=0 and no error sets busy=1 and clears done.
  - o_start=1 for exactly the one cycle after the commit edge.
  - A CMD write with bit0=0 is a legal no-op.
- Completion:
  - i_result_valid while busy: result←i_result_class, busy←0, done←1 on that edge.
  - i_result_valid while not busy is ignored.
- Simultaneous events:
  - A done W1C committing on the same edge as i_result_valid: set wins, done=1.
  - A CMD start committing on the same edge as i_result_valid: cannot occur, because busy blocks the start.
- PSTRB: byte b is written only if PSTRB[b]=1. PSTRB=0 write is legal, no change.

Test Plan:
- Reset held 5 cycles, then read idx 0 -> PRDATA=ID_VALUE, PSLVERR=0. PREADY asserts on the 3rd access cycle (WAIT_STATES=1).
- Write idx 10=32'hDEADBEEF, then idx 41=32'h12345678 with PSTRB=4'b0011 -> o_img_data[31:0]=DEADBEEF, o_img_data[1023:992]=00005678; readback matches.
- Write idx 44=32'h000522A5 -> o_model_params=19'h522A5. Write CMD=1 -> o_start high exactly 1 cycle, STATUS=1. Then write idx 10 -> PSLVERR=1 and the word is unchanged.
- Pulse i_result_valid with class=4'd3 -> STATUS=2, RESULT=32'h103. Write STATUS=2 -> STATUS=0, RESULT=32'h003.
- Read idx 45 and write idx 43 -> PSLVERR=1, PRDATA=0, no state change. Drop PENABLE during WAIT on a write -> no commit.
- Assert i_rst mid-access after writing idx 20 -> all outputs 0, o_PREADY=0, o_img_data=0; next transfer completes normally.

Source files
------------

// File: rtl/apb_accel_reg_slave.sv
// APB completer holding the accelerator register map: image words, command,
// result and model parameters, with programmable wait states and PSLVERR.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in progress; an access phase loads the wait counter
// WAIT  | PREADY held low while the wait counter runs down
// RESP  | PREADY high, PRDATA/PSLVERR valid; writes commit on the next edge
module apb_accel_reg_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hACC0_0001
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_PSEL,
  input  logic          i_PENABLE,
  input  logic          i_PWRITE,
  input  logic [9:0]    i_PADDR,
  input  logic [31:0]   i_PWDATA,
  input  logic [3:0]    i_PSTRB,
  output logic [31:0]   o_PRDATA,
  output logic          o_PREADY,
  output logic          o_PSLVERR,
  input  logic          i_result_valid,
  input  logic [3:0]    i_result_class,
  output logic [1023:0] o_img_data,
  output logic [18:0]   o_model_params,
  output logic          o_start
);

  localparam logic [3:0] WAIT_CNT   = 4'(WAIT_STATES);
  localparam logic [9:0] IDX_ID     = 10'd0;
  localparam logic [9:0] IDX_STATUS = 10'd1;
  localparam logic [9:0] IDX_IMG_LO = 10'd10;
  localparam logic [9:0] IDX_IMG_HI = 10'd41;
  localparam logic [9:0] IDX_CMD    = 10'd42;
  localparam logic [9:0] IDX_RESULT = 10'd43;
  localparam logic [9:0] IDX_PARAMS = 10'd44;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [1023:0]   img_q;
  logic [18:0]     params_q;
  logic            busy_q, done_q, start_q;
  logic [3:0]      result_q;

  logic            access, resp_active, wr_commit;
  logic            hit_id, hit_status, hit_img, hit_cmd, hit_result, hit_params;
  logic            mapped, err;
  logic [4:0]      img_idx;
  logic [9:0]      img_base;
  logic [31:0]     rd_word;

  assign access      = i_PSEL & i_PENABLE;
  assign resp_active = (state_q == ST_RESP) & access;

  assign hit_id     = (i_PADDR == IDX_ID);
  assign hit_status = (i_PADDR == IDX_STATUS);
  assign hit_img    = (i_PADDR >= IDX_IMG_LO) & (i_PADDR <= IDX_IMG_HI);
  assign hit_cmd    = (i_PADDR == IDX_CMD);
  assign hit_result = (i_PADDR == IDX_RESULT);
  assign hit_params = (i_PADDR == IDX_PARAMS);
  assign mapped     = hit_id | hit_status | hit_img | hit_cmd | hit_result | hit_params;

  assign img_idx  = 5'(i_PADDR - IDX_IMG_LO);
  assign img_base = {img_idx, 5'd0};

  // Busy only locks the registers that feed the running inference; STATUS stays writable.
  assign err = ~mapped
             | (i_PWRITE & (hit_id | hit_result
                            | (hit_status & i_PWDATA[0] & i_PSTRB[0])
                            | (busy_q & (hit_img | hit_cmd | hit_params))));

  assign wr_commit = resp_active & i_PWRITE & ~err;

  // State register and wait-state down-counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; an access dropping before completion returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_CNT != 4'd0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!access) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux for the addressed register.
  always_comb begin
    rd_word = '0;
    if (hit_id)          rd_word = ID_VALUE;
    else if (hit_status) rd_word = {30'b0, done_q, busy_q};
    else if (hit_img)    rd_word = img_q[img_base +: 32];
    else if (hit_result) rd_word = {23'b0, done_q, 4'b0, result_q};
    else if (hit_params) rd_word = {13'b0, params_q};
  end

  assign o_PREADY  = resp_active;
  assign o_PSLVERR = resp_active & err;
  assign o_PRDATA  = (resp_active & ~i_PWRITE & ~err) ? rd_word : 32'd0;

  // Register file commit, start pulse and result capture; completion is applied
  // last so that a done set beats a same-edge W1C.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      img_q    <= '0;
      params_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      result_q <= '0;
    end else begin
      start_q <= 1'b0;
      if (wr_commit) begin
        if (hit_img) begin
          for (int b = 0; b < 4; b++) begin
            if (i_PSTRB[b]) img_q[img_base + 10'(8*b) +: 8] <= i_PWDATA[8*b +: 8];
          end
        end
        if (hit_params) begin
          if (i_PSTRB[0]) params_q[7:0]   <= i_PWDATA[7:0];
          if (i_PSTRB[1]) params_q[15:8]  <= i_PWDATA[15:8];
          if (i_PSTRB[2]) params_q[18:16] <= i_PWDATA[18:16];
        end
        if (hit_status && i_PSTRB[0] && i_PWDATA[1]) done_q <= 1'b0;
        if (hit_cmd && i_PSTRB[0] && i_PWDATA[0]) begin
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          start_q <= 1'b1;
        end
      end
      if (i_result_valid && busy_q) begin
        result_q <= i_result_class;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
      end
    end
  end

  assign o_img_data     = img_q;
  assign o_model_params = params_q;
  assign o_start        = start_q;

endmodule

// File: tb/tb_apb_accel_reg_slave.sv
// Directed bench for apb_accel_reg_slave: vector table plus corner sequences.
module tb_apb_accel_reg_slave;

  logic          clk_tb = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [9:0]    paddr;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic          result_valid;
  logic [3:0]    result_class;
  logic [1023:0] img_data;
  logic [18:0]   model_params;
  logic          start;

  int n_checks = 0;
  int n_pass   = 0;

  apb_accel_reg_slave #(.WAIT_STATES(1), .ID_VALUE(32'hACC0_0001)) dut (
    .i_clk(clk_tb), .i_rst(rst),
    .i_PSEL(psel), .i_PENABLE(penable), .i_PWRITE(pwrite),
    .i_PADDR(paddr), .i_PWDATA(pwdata), .i_PSTRB(pstrb),
    .o_PRDATA(prdata), .o_PREADY(pready), .o_PSLVERR(pslverr),
    .i_result_valid(result_valid), .i_result_class(result_class),
    .o_img_data(img_data), .o_model_params(model_params), .o_start(start)
  );

  always #5 clk_tb = ~clk_tb;

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Full APB transfer; called and returns #1 after a clock edge.
  task automatic apb(input bit wr, input logic [9:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, input bit rv_at_resp,
                     output logic [31:0] rd, output logic err, output int cyc);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(posedge clk_tb); #1;
    penable = 1'b1;
    cyc = 1;
    while (!pready && cyc < 40) begin
      @(posedge clk_tb); #1;
      cyc++;
    end
    rd  = prdata;
    err = pslverr;
    if (!pready) chk("pready_timeout", 64'(pready), 64'd1);
    if (rv_at_resp) begin
      result_valid = 1'b1;
      result_class = 4'd7;
    end
    @(posedge clk_tb); #1;
    result_valid = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_rd(input string name, input logic [9:0] addr,
                       input logic [31:0] exp, input bit exp_err);
    logic [31:0] rd; logic err; int cyc;
    apb(1'b0, addr, 32'd0, 4'hF, 1'b0, rd, err, cyc);
    chk({name, "_rdata"}, 64'(rd), 64'(exp));
    chk({name, "_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic do_wr(input string name, input logic [9:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input bit exp_err);
    logic [31:0] rd; logic err; int cyc;
    apb(1'b1, addr, wd, st, 1'b0, rd, err, cyc);
    chk({name, "_err"}, 64'(err), 64'(exp_err));
    chk({name, "_rdata"}, 64'(rd), 64'd0);
  endtask

  task automatic pulse_result(input logic [3:0] cls);
    result_valid = 1'b1; result_class = cls;
    @(posedge clk_tb); #1;
    result_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_pready"}, 64'(pready), 64'd0);
    chk({name, "_pslverr"}, 64'(pslverr), 64'd0);
    chk({name, "_prdata"}, 64'(prdata), 64'd0);
    chk({name, "_start"}, 64'(start), 64'd0);
    chk({name, "_img"}, 64'(|img_data), 64'd0);
    chk({name, "_params"}, 64'(model_params), 64'd0);
  endtask

  initial begin
    logic [31:0] rd; logic err; int cyc;

    // {wr, addr, wdata, strb, expected rdata, expected pslverr}
    vecs.push_back('{1'b0, 10'd0,    32'h0,        4'hF, 32'hACC00001, 1'b0});
    vecs.push_back('{1'b1, 10'd10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 10'd41,   32'h12345678, 4'h3, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 10'd10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 10'd41,   32'h0,        4'hF, 32'h00005678, 1'b0});
    vecs.push_back('{1'b1, 10'd44,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 10'd44,   32'h0,        4'hF, 32'h0007FFFF, 1'b0});
    vecs.push_back('{1'b1, 10'd44,   32'h000522A5, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 10'd44,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 10'd44,   32'h0,        4'hF, 32'h000522A5, 1'b0});
    vecs.push_back('{1'b1, 10'd44,   32'hFFFFFFFF, 4'h4, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 10'd44,   32'h0,        4'hF, 32'h000722A5, 1'b0});
    vecs.push_back('{1'b1, 10'd44,   32'h00050000, 4'h4, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 10'd44,   32'h0,        4'hF, 32'h000522A5, 1'b0});
    vecs.push_back('{1'b0, 10'd45,   32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 10'd9,    32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 10'd1023, 32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 10'd43,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 10'd0,    32'h12345678, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 10'd1,    32'h00000001, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 10'd42,   32'h00000000, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 10'd1,    32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 10'd43,   32'h0,        4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 10'd0,    32'h0,        4'hF, 32'hACC00001, 1'b0});

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; result_valid = 1'b0; result_class = '0;
    repeat (5) @(posedge clk_tb);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 1'b0, rd, err, cyc);
      chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'd3);
      chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
    end
    chk("img_w0", 64'(img_data[31:0]), 64'hDEADBEEF);
    chk("img_w31", 64'(img_data[1023:992]), 64'h00005678);
    chk("params", 64'(model_params), 64'h522A5);
    chk("no_start", 64'(start), 64'd0);

    // Start inference: one-cycle pulse, busy set, locked registers.
    do_wr("cmd_start", 10'd42, 32'h1, 4'hF, 1'b0);
    chk("start_pulse", 64'(start), 64'd1);
    @(posedge clk_tb); #1;
    chk("start_low", 64'(start), 64'd0);
    do_rd("status_busy", 10'd1, 32'h1, 1'b0);
    do_wr("img_busy", 10'd10, 32'h0, 4'hF, 1'b1);
    do_rd("img_kept", 10'd10, 32'hDEADBEEF, 1'b0);
    do_wr("params_busy", 10'd44, 32'h0, 4'hF, 1'b1);
    do_wr("cmd_busy", 10'd42, 32'h1, 4'hF, 1'b1);
    chk("no_restart", 64'(start), 64'd0);
    chk("params_kept", 64'(model_params), 64'h522A5);

    // Completion and done W1C.
    pulse_result(4'd3);
    do_rd("status_done", 10'd1, 32'h2, 1'b0);
    do_rd("result_done", 10'd43, 32'h103, 1'b0);
    do_wr("status_w1c", 10'd1, 32'h2, 4'hF, 1'b0);
    do_rd("status_clr", 10'd1, 32'h0, 1'b0);
    do_rd("result_clr", 10'd43, 32'h003, 1'b0);
    pulse_result(4'd5);
    do_rd("result_idle_pulse", 10'd43, 32'h003, 1'b0);
    do_rd("status_idle_pulse", 10'd1, 32'h0, 1'b0);

    // W1C and completion on the same edge: the set wins.
    do_wr("cmd_start2", 10'd42, 32'h1, 4'hF, 1'b0);
    apb(1'b1, 10'd1, 32'h2, 4'hF, 1'b1, rd, err, cyc);
    chk("w1c_race_err", 64'(err), 64'd0);
    do_rd("status_race", 10'd1, 32'h2, 1'b0);
    do_rd("result_race", 10'd43, 32'h107, 1'b0);

    // PENABLE dropping during WAIT aborts the write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'd11; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk_tb); #1;
    penable = 1'b1;
    @(posedge clk_tb); #1;
    chk("abort_wait_pready", 64'(pready), 64'd0);
    penable = 1'b0;
    @(posedge clk_tb); #1;
    chk("abort_idle_pready", 64'(pready), 64'd0);
    psel = 1'b0; pwrite = 1'b0;
    @(posedge clk_tb); #1;
    apb(1'b0, 10'd11, 32'h0, 4'hF, 1'b0, rd, err, cyc);
    chk("abort_word", 64'(rd), 64'd0);
    chk("abort_next_cycles", 64'(cyc), 64'd3);

    // Reset in the middle of an access.
    do_wr("pre_rst_w20", 10'd20, 32'h11112222, 4'hF, 1'b0);
    do_rd("pre_rst_r20", 10'd20, 32'h11112222, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'd21; pwdata = 32'hAAAA5555; pstrb = 4'hF;
    @(posedge clk_tb); #1;
    penable = 1'b1;
    @(posedge clk_tb); #1;
    rst = 1'b1;
    @(posedge clk_tb); #1;
    chk("rst_mid_pready", 64'(pready), 64'd0);
    @(posedge clk_tb); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk_tb); #1;
    rst = 1'b0;
    chk_all_zero("rst_mid");
    do_rd("post_rst_r20", 10'd20, 32'h0, 1'b0);
    do_rd("post_rst_r21", 10'd21, 32'h0, 1'b0);
    do_rd("post_rst_status", 10'd1, 32'h0, 1'b0);
    do_rd("post_rst_result", 10'd43, 32'h0, 1'b0);
    apb(1'b1, 10'd20, 32'h0BADF00D, 4'hF, 1'b0, rd, err, cyc);
    chk("post_rst_wr_cycles", 64'(cyc), 64'd3);
    chk("post_rst_wr_err", 64'(err), 64'd0);
    do_rd("post_rst_r20b", 10'd20, 32'h0BADF00D, 1'b0);
    chk("post_rst_img", 64'(img_data[351:320]), 64'h0BADF00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
